// File: rtl/ula_sub_result_stage.sv
// ---------------------------------------------------------------------------
// ula_sub_result_stage
//
// Purpose
//   Result stage behind a 32-bit subtractor. It derives the condition flags
//   {Z, N, C, V} and the signed/unsigned less-than results for each
//   subtraction. The difference and flags are buffered in a small FIFO so the
//   subtractor can be decoupled from the consumer. Outputs appear one cycle
//   after acceptance. No combinational path runs from in_* to out_*.
//
// Handshake (both sides)
//   A transfer happens on a rising edge where valid=1 and ready=1. Once a
//   producer raises valid, it holds it and its data until that edge. in_ready
//   comes from a register and is forced low while rst is high. It never
//   depends on out_ready, so a full buffer only accepts input again the cycle
//   after a pop.
//
// Parameters
//   DEPTH     result-buffer entries (power of two, >= 2)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  upstream result present
//   in_ready  stage can accept a result this cycle
//   s_in      [31:0] difference a-b, [32] borrow-out
//   a_msb     bit 31 of minuend a
//   b_msb     bit 31 of subtrahend b
//   out_valid head entry valid
//   out_ready downstream accepts head entry
//   out_diff  head difference (0 when out_valid=0)
//   out_flags head {Z, N, C, V}, bit 3 = Z (0 when out_valid=0)
//   out_lt    signed a<b of head entry (N^V)
//   out_ltu   unsigned a<b of head entry (C)
//   op_count  completed output transfers, wraps at 16 bits
// ---------------------------------------------------------------------------
module ula_sub_result_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [32:0] s_in,
   input  logic        a_msb,
   input  logic        b_msb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_diff,
   output logic [3:0]  out_flags,
   output logic        out_lt,
   output logic        out_ltu,
   output logic [15:0] op_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   mem_diff  [DEPTH];
   logic [3:0]    mem_flags [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          in_ready_q;
   logic          push;
   logic          pop;

   logic          enq_z;
   logic          enq_n;
   logic          enq_c;
   logic          enq_v;
   logic [3:0]    enq_flags;

   logic [3:0]    head_flags;

   // Flags are derived at enqueue so that the buffer holds final results.
   // V: the operands differ in sign and the result sign differs from a.
   always_comb begin
      enq_z     = (s_in[31:0] == 32'h0);
      enq_n     = s_in[31];
      enq_c     = s_in[32];
      enq_v     = (a_msb ^ b_msb) & (a_msb ^ s_in[31]);
      enq_flags = {enq_z, enq_n, enq_c, enq_v};
   end

   // rst gates in_ready so nothing is accepted while it is held.
   assign in_ready  = in_ready_q & ~rst;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         in_ready_q <= 1'b1;
         op_count   <= 16'h0000;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            op_count <= op_count + 16'h0001;
         end
         count      <= count_next;
         in_ready_q <= (count_next != FULL_CNT);
      end
   end

   // Storage is left unreset; only the occupancy decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_diff[wr_ptr]  <= s_in[31:0];
         mem_flags[wr_ptr] <= enq_flags;
      end
   end

   assign head_flags = mem_flags[rd_ptr];

   always_comb begin
      out_diff  = 32'h0;
      out_flags = 4'h0;
      out_lt    = 1'b0;
      out_ltu   = 1'b0;
      if (out_valid) begin
         out_diff  = mem_diff[rd_ptr];
         out_flags = head_flags;
         out_lt    = head_flags[2] ^ head_flags[0];
         out_ltu   = head_flags[1];
      end
   end

endmodule

// File: tb/tb_ula_sub_result_stage.sv
// ---------------------------------------------------------------------------
// tb_ula_sub_result_stage
//
// Directed bench for ula_sub_result_stage with DEPTH=2. Inputs are driven
// 1 ns after a rising edge and outputs are sampled at that point too.
// Expected values are written out by hand from the flag equations.
// ---------------------------------------------------------------------------
module tb_ula_sub_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [32:0] s_in;
   logic        a_msb;
   logic        b_msb;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_diff;
   logic [3:0]  out_flags;
   logic        out_lt;
   logic        out_ltu;
   logic [15:0] op_count;

   int checks;
   int errors;

   ula_sub_result_stage #(.DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s_in      (s_in),
      .a_msb     (a_msb),
      .b_msb     (b_msb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_flags (out_flags),
      .out_lt    (out_lt),
      .out_ltu   (out_ltu),
      .op_count  (op_count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      s_in      = '0;
      a_msb     = 1'b0;
      b_msb     = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic drive_push(input logic [32:0] s, input logic a, input logic b);
      in_valid = 1'b1;
      s_in     = s;
      a_msb    = a;
      b_msb    = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drive_pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      s_in      = '0;
      a_msb     = 1'b0;
      b_msb     = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready_during_rst got %b exp 0", in_ready);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_diff, out_flags, out_lt, out_ltu, op_count} !==
          {1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL reset_state got v=%b r=%b d=%h f=%h lt=%b ltu=%b cnt=%h exp v=0 r=1 all 0",
                  out_valid, in_ready, out_diff, out_flags, out_lt, out_ltu, op_count);
      end
      // out_ready with nothing buffered must do nothing
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, 16'h0}) begin
         errors++;
         $display("FAIL empty_pop_noop got v=%b r=%b cnt=%h exp v=0 r=1 cnt=0000",
                  out_valid, in_ready, op_count);
      end
   endtask

   task automatic test_flags();
      logic [32:0] v_s   [5];
      logic        v_a   [5];
      logic        v_b   [5];
      logic [3:0]  v_f   [5];
      logic        v_lt  [5];
      logic        v_ltu [5];
      // 5-3
      v_s[0] = 33'h0_00000002; v_a[0] = 0; v_b[0] = 0; v_f[0] = 4'b0000; v_lt[0] = 0; v_ltu[0] = 0;
      // 3-5
      v_s[1] = 33'h1_FFFFFFFE; v_a[1] = 0; v_b[1] = 0; v_f[1] = 4'b0110; v_lt[1] = 1; v_ltu[1] = 1;
      // 0x80000000-1 : signed overflow
      v_s[2] = 33'h0_7FFFFFFF; v_a[2] = 1; v_b[2] = 0; v_f[2] = 4'b0001; v_lt[2] = 1; v_ltu[2] = 0;
      // equal operands
      v_s[3] = 33'h0_00000000; v_a[3] = 0; v_b[3] = 0; v_f[3] = 4'b1000; v_lt[3] = 0; v_ltu[3] = 0;
      // 0-0x80000000 : overflow with b negative
      v_s[4] = 33'h1_80000000; v_a[4] = 0; v_b[4] = 1; v_f[4] = 4'b0111; v_lt[4] = 0; v_ltu[4] = 1;
      drive_reset();
      for (int i = 0; i < 5; i++) begin
         drive_push(v_s[i], v_a[i], v_b[i]);
         checks++;
         if ({out_valid, out_diff, out_flags, out_lt, out_ltu} !==
             {1'b1, v_s[i][31:0], v_f[i], v_lt[i], v_ltu[i]}) begin
            errors++;
            $display("FAIL flags_vec%0d got v=%b d=%h f=%b lt=%b ltu=%b exp v=1 d=%h f=%b lt=%b ltu=%b",
                     i, out_valid, out_diff, out_flags, out_lt, out_ltu,
                     v_s[i][31:0], v_f[i], v_lt[i], v_ltu[i]);
         end
         drive_pop();
         checks++;
         if ({out_valid, out_diff, out_flags, out_lt, out_ltu} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_zero_vec%0d got v=%b d=%h f=%b lt=%b ltu=%b exp all 0",
                     i, out_valid, out_diff, out_flags, out_lt, out_ltu);
         end
      end
      checks++;
      if (op_count !== 16'd5) begin
         errors++;
         $display("FAIL flags_op_count got %0d exp 5", op_count);
      end
   endtask

   task automatic test_back_to_back();
      drive_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a_msb     = 1'b0;
      b_msb     = 1'b0;
      s_in      = 33'h0_00000011;  // A
      step();
      s_in = 33'h0_00000022;       // B
      checks++;
      if ({in_ready, out_valid, out_diff} !== {1'b1, 1'b1, 32'h11}) begin
         errors++;
         $display("FAIL b2b_after_a got r=%b v=%b d=%h exp r=1 v=1 d=00000011", in_ready, out_valid, out_diff);
      end
      step();
      s_in = 33'h0_00000033;       // C
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_full_after_b got r=%b exp 0", in_ready);
      end
      step();
      // C is still offered but must not be taken, and the head must stay A
      checks++;
      if ({in_ready, out_valid, out_diff, out_flags} !== {1'b0, 1'b1, 32'h11, 4'h0}) begin
         errors++;
         $display("FAIL b2b_stall_hold got r=%b v=%b d=%h f=%b exp r=0 v=1 d=00000011 f=0000",
                  in_ready, out_valid, out_diff, out_flags);
      end
      out_ready = 1'b1;
      step();                      // A pops, still full this edge so C not taken
      checks++;
      if ({in_ready, out_valid, out_diff, op_count} !== {1'b1, 1'b1, 32'h22, 16'd1}) begin
         errors++;
         $display("FAIL b2b_a_popped got r=%b v=%b d=%h cnt=%0d exp r=1 v=1 d=00000022 cnt=1",
                  in_ready, out_valid, out_diff, op_count);
      end
      step();                      // B pops, C pushed
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, out_diff, op_count} !== {1'b1, 1'b1, 32'h33, 16'd2}) begin
         errors++;
         $display("FAIL b2b_b_popped got r=%b v=%b d=%h cnt=%0d exp r=1 v=1 d=00000033 cnt=2",
                  in_ready, out_valid, out_diff, op_count);
      end
      step();                      // C pops
      out_ready = 1'b0;
      checks++;
      if ({out_valid, op_count} !== {1'b0, 16'd3}) begin
         errors++;
         $display("FAIL b2b_drained got v=%b cnt=%0d exp v=0 cnt=3", out_valid, op_count);
      end
   endtask

   task automatic test_reset_in_flight();
      drive_reset();
      for (int i = 0; i < 5; i++) begin
         drive_push(33'(i + 1), 1'b0, 1'b0);
         drive_pop();
      end
      drive_push(33'h0_0000AAAA, 1'b0, 1'b0);
      drive_push(33'h0_0000BBBB, 1'b0, 1'b0);
      checks++;
      if ({out_valid, in_ready, out_diff, op_count} !== {1'b1, 1'b0, 32'hAAAA, 16'd5}) begin
         errors++;
         $display("FAIL rif_setup got v=%b r=%b d=%h cnt=%0d exp v=1 r=0 d=0000aaaa cnt=5",
                  out_valid, in_ready, out_diff, op_count);
      end
      rst       = 1'b1;
      in_valid  = 1'b1;
      s_in      = 33'h0_0000CCCC;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rif_in_ready_during_rst got %b exp 0", in_ready);
      end
      step();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_diff, out_flags, op_count} !== {1'b0, 1'b1, 32'h0, 4'h0, 16'h0}) begin
         errors++;
         $display("FAIL rif_after_rst got v=%b r=%b d=%h f=%b cnt=%h exp v=0 r=1 d=0 f=0 cnt=0000",
                  out_valid, in_ready, out_diff, out_flags, op_count);
      end
      step();
      checks++;
      if ({out_valid, op_count} !== {1'b0, 16'h0}) begin
         errors++;
         $display("FAIL rif_no_survivor got v=%b cnt=%h exp v=0 cnt=0000", out_valid, op_count);
      end
   endtask

   // Continuous push+pop at occupancy 1 until op_count wraps.
   task automatic test_stream_wrap();
      int bad;
      bad = 0;
      drive_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a_msb     = 1'b0;
      b_msb     = 1'b0;
      s_in      = 33'd0;
      for (int j = 1; j <= 65536; j++) begin
         step();
         // j pushes done (values 0..j-1), j-1 pops done
         if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
             out_diff !== 32'(j - 1) || op_count !== 16'(j - 1))
            bad++;
         s_in = 33'(j);
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stream_steady got %0d bad cycles exp 0", bad);
      end
      checks++;
      if ({op_count, out_diff} !== {16'hFFFF, 32'd65535}) begin
         errors++;
         $display("FAIL stream_pre_wrap got cnt=%h d=%h exp cnt=ffff d=0000ffff", op_count, out_diff);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, op_count} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL stream_wrap got v=%b cnt=%h exp v=0 cnt=0000", out_valid, op_count);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_flags();
      test_back_to_back();
      test_reset_in_flight();
      test_stream_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
